// File: rtl/spike_pattern_decoder.sv
// rtl/spike_pattern_decoder.sv - integrates per-neuron spike counts over a fixed window and decodes a binary pattern
module spike_pattern_decoder #(
  parameter int N          = 7,
  parameter int WINDOW     = 64,
  parameter int CNT_W      = 6,
  parameter int MIN_SPIKES = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         abort,
  input  logic [N-1:0] spikes,
  output logic         busy,
  output logic [N-1:0] pattern_out,
  output logic [2:0]   active_count,
  output logic         pattern_valid,
  input  logic         pattern_ready
);

  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [7:0]       WIN_LAST = 8'(WINDOW - 1);

  state_t           state;
  logic [7:0]       win_cnt;
  logic [CNT_W-1:0] cnt      [N];
  logic [CNT_W-1:0] cnt_next [N];
  logic [N-1:0]     decode;
  logic [2:0]       decode_pop;

  // cnt_next already includes the current cycle's spikes, so the final
  // window cycle is counted when the decision is registered.
  always_comb begin
    decode_pop = '0;
    for (int i = 0; i < N; i++) begin
      cnt_next[i] = (spikes[i] && (cnt[i] != CNT_MAX)) ? cnt[i] + CNT_W'(1) : cnt[i];
      decode[i]   = 32'(cnt_next[i]) >= 32'(MIN_SPIKES);
      decode_pop  = decode_pop + 3'(decode[i]);
    end
  end

  always_comb begin
    busy = (state == COUNT) || (state == HOLD);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      win_cnt       <= '0;
      pattern_out   <= '0;
      active_count  <= '0;
      pattern_valid <= 1'b0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else if (abort) begin
      // pattern_out/active_count deliberately keep the last accepted result
      state         <= IDLE;
      win_cnt       <= '0;
      pattern_valid <= 1'b0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= COUNT;
            win_cnt <= '0;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
          end
        end
        COUNT: begin
          for (int i = 0; i < N; i++) cnt[i] <= cnt_next[i];
          win_cnt <= win_cnt + 8'd1;
          if (win_cnt == WIN_LAST) begin
            state         <= HOLD;
            pattern_out   <= decode;
            active_count  <= decode_pop;
            pattern_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (pattern_ready) begin
            state         <= IDLE;
            pattern_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
